// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-select codes, load funct3 codes
// and the stage state type.
package wb_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle between MEM stage / data memory (master side) and the writeback stage
// (slave side), including the register-file write port and status outputs.
interface writeback_stage_if #(
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             in_reg_write;
   logic [4:0]       in_rd;
   logic [1:0]       in_wb_sel;
   logic [31:0]      in_alu_result;
   logic [31:0]      in_pc_plus4;
   logic [2:0]       in_funct3;
   logic             dmem_rvalid;
   logic [31:0]      dmem_rdata;
   logic             RegWrite;
   logic [4:0]       rd_addr;
   logic [31:0]      write_data;
   logic             load_pending;
   logic [4:0]       pending_rd;
   logic [CNT_W-1:0] retire_count;
   logic             load_err;

   modport master (
      output in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
             in_pc_plus4, in_funct3, dmem_rvalid, dmem_rdata,
      input  in_ready, RegWrite, rd_addr, write_data, load_pending,
             pending_rd, retire_count, load_err
   );

   modport slave (
      input  in_valid, in_reg_write, in_rd, in_wb_sel, in_alu_result,
             in_pc_plus4, in_funct3, dmem_rvalid, dmem_rdata,
      output in_ready, RegWrite, rd_addr, write_data, load_pending,
             pending_rd, retire_count, load_err
   );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational load extractor: picks the byte/halfword addressed by off out of
// the memory word and sign- or zero-extends it according to funct3.
module load_align
   import wb_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   output logic [31:0] data32
);

   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   always_comb begin
      case (off)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         default: byte_s = rdata[31:24];
      endcase
      // off[0] is irrelevant for halfwords; misaligned accesses never reach here
      half_s = off[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_LB:   data32 = 32'(byte_s);
         F3_LH:   data32 = 32'(half_s);
         F3_LBU:  data32 = {24'd0, byte_s};
         F3_LHU:  data32 = {16'd0, half_s};
         default: data32 = rdata;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires instructions into the register file, waits for load
// data when needed. Optional load timeout enabled by defining WB_LOAD_TIMEOUT_EN.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int CNT_W = 32
`ifdef WB_LOAD_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
)(
   input  logic               clk,
   input  logic               reset_n,
   writeback_stage_if.slave   bus
);

   wb_state_t state, state_nxt;

   logic [4:0]       hold_rd;
   logic             hold_we;
   logic [2:0]       hold_funct3;
   logic [1:0]       hold_off;

   logic             wr_vld_p0;
   logic             wr_en_p0;
   logic [4:0]       wr_rd_p0;
   logic [31:0]      wr_data_p0;
   logic             capture;
   logic             timeout_hit;

   logic             reg_write_p1;
   logic [4:0]       rd_p1;
   logic [31:0]      data_p1;
   logic [CNT_W-1:0] retire_cnt;
   logic             load_err_q;

   logic [2:0]       al_funct3;
   logic [1:0]       al_off;
   logic [31:0]      al_data;

   logic             accept;
   logic             is_load;

   assign accept  = bus.in_valid && (state == IDLE);
   assign is_load = (bus.in_wb_sel == WB_SEL_LOAD);

   // One aligner serves both the same-cycle path and the held (delayed) load
   assign al_funct3 = (state == WAIT_LOAD) ? hold_funct3 : bus.in_funct3;
   assign al_off    = (state == WAIT_LOAD) ? hold_off    : bus.in_alu_result[1:0];

   load_align u_align (
      .funct3 (al_funct3),
      .off    (al_off),
      .rdata  (bus.dmem_rdata),
      .data32 (al_data)
   );

`ifdef WB_LOAD_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_cnt;

   assign timeout_hit = (state == WAIT_LOAD) && !bus.dmem_rvalid &&
                        (int'(wait_cnt) >= TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (capture) begin
         wait_cnt <= '0;
      end else if (state == WAIT_LOAD && !bus.dmem_rvalid && !timeout_hit) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      wr_vld_p0  = 1'b0;
      wr_en_p0   = 1'b0;
      wr_rd_p0   = rd_p1;
      wr_data_p0 = data_p1;
      capture    = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               if (!is_load) begin
                  wr_vld_p0  = 1'b1;
                  wr_en_p0   = bus.in_reg_write && (bus.in_rd != 5'd0);
                  wr_rd_p0   = bus.in_rd;
                  wr_data_p0 = (bus.in_wb_sel == WB_SEL_PC4) ? bus.in_pc_plus4
                                                            : bus.in_alu_result;
               end else if (bus.dmem_rvalid) begin
                  wr_vld_p0  = 1'b1;
                  wr_en_p0   = bus.in_reg_write && (bus.in_rd != 5'd0);
                  wr_rd_p0   = bus.in_rd;
                  wr_data_p0 = al_data;
               end else begin
                  capture    = 1'b1;
                  state_nxt  = WAIT_LOAD;
               end
            end
         end
         WAIT_LOAD: begin
            if (bus.dmem_rvalid) begin
               wr_vld_p0  = 1'b1;
               wr_en_p0   = hold_we && (hold_rd != 5'd0);
               wr_rd_p0   = hold_rd;
               wr_data_p0 = al_data;
               state_nxt  = IDLE;
            end else if (timeout_hit) begin
               wr_vld_p0  = 1'b1;
               wr_en_p0   = hold_we && (hold_rd != 5'd0);
               wr_rd_p0   = hold_rd;
               wr_data_p0 = 32'd0;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         hold_rd     <= 5'd0;
         hold_we     <= 1'b0;
         hold_funct3 <= 3'd0;
         hold_off    <= 2'd0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            hold_rd     <= bus.in_rd;
            hold_we     <= bus.in_reg_write;
            hold_funct3 <= bus.in_funct3;
            hold_off    <= bus.in_alu_result[1:0];
         end
      end
   end

   // ---- stage p1: register-file write port and retire bookkeeping ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_write_p1 <= 1'b0;
         rd_p1        <= 5'd0;
         data_p1      <= 32'd0;
         retire_cnt   <= '0;
         load_err_q   <= 1'b0;
      end else begin
         reg_write_p1 <= wr_en_p0;
         if (wr_en_p0) begin
            rd_p1   <= wr_rd_p0;
            data_p1 <= wr_data_p0;
         end
         if (wr_vld_p0) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
         end
         if (timeout_hit) begin
            load_err_q <= 1'b1;
         end
      end
   end

   assign bus.in_ready     = (state == IDLE);
   assign bus.load_pending = (state == WAIT_LOAD);
   assign bus.pending_rd   = ((state == WAIT_LOAD) && hold_we) ? hold_rd : 5'd0;
   assign bus.RegWrite     = reg_write_p1;
   assign bus.rd_addr      = rd_p1;
   assign bus.write_data   = data_p1;
   assign bus.retire_count = retire_cnt;
   assign bus.load_err     = load_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage; the timeout section is active when
// WB_LOAD_TIMEOUT_EN is defined (DUT then built with TIMEOUT_CYCLES=4).
module tb_writeback_stage;
   import wb_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   writeback_stage_if #(.CNT_W(32)) bus ();

`ifdef WB_LOAD_TIMEOUT_EN
   writeback_stage #(.CNT_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );
`else
   writeback_stage #(.CNT_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid      = 1'b0;
      bus.in_reg_write  = 1'b0;
      bus.in_rd         = 5'd0;
      bus.in_wb_sel     = WB_SEL_ALU;
      bus.in_alu_result = 32'd0;
      bus.in_pc_plus4   = 32'd0;
      bus.in_funct3     = 3'd0;
      bus.dmem_rvalid   = 1'b0;
      bus.dmem_rdata    = 32'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for exactly one cycle; returns 1ns after the edge
   task automatic issue(input logic [1:0] sel, input logic we, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [2:0] f3, input logic rv, input logic [31:0] rdata);
      bus.in_valid      = 1'b1;
      bus.in_wb_sel     = sel;
      bus.in_reg_write  = we;
      bus.in_rd         = rd;
      bus.in_alu_result = alu;
      bus.in_pc_plus4   = pc4;
      bus.in_funct3     = f3;
      bus.dmem_rvalid   = rv;
      bus.dmem_rdata    = rdata;
      tick();
      idle_inputs();
   endtask

   task automatic rvalid_pulse(input logic [31:0] rdata);
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = rdata;
      tick();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      check("rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
      check("rst_retire", bus.retire_count, 32'd0);
      check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_pending", {31'd0, bus.load_pending}, 32'd0);
      check("rst_err", {31'd0, bus.load_err}, 32'd0);
      reset_n = 1'b1;
      tick();

      // ALU path
      issue(WB_SEL_ALU, 1'b1, 5'd5, 32'h12345678, 32'h0, 3'd0, 1'b0, 32'h0);
      check("alu_we", {31'd0, bus.RegWrite}, 32'd1);
      check("alu_rd", {27'd0, bus.rd_addr}, 32'd5);
      check("alu_data", bus.write_data, 32'h12345678);
      check("alu_retire", bus.retire_count, 32'd1);

      // x0 and no-write instructions retire but never assert RegWrite
      issue(WB_SEL_ALU, 1'b1, 5'd0, 32'hDEADBEEF, 32'h0, 3'd0, 1'b0, 32'h0);
      check("x0_we", {31'd0, bus.RegWrite}, 32'd0);
      check("x0_rd_hold", {27'd0, bus.rd_addr}, 32'd5);
      issue(WB_SEL_ALU, 1'b0, 5'd3, 32'hCAFEF00D, 32'h0, 3'd0, 1'b0, 32'h0);
      check("nowr_we", {31'd0, bus.RegWrite}, 32'd0);
      check("nowr_data_hold", bus.write_data, 32'h12345678);
      check("nowr_retire", bus.retire_count, 32'd3);

      // PC+4 and sel=11 (treated as ALU), back to back
      issue(WB_SEL_PC4, 1'b1, 5'd1, 32'h55, 32'h00001004, 3'd0, 1'b0, 32'h0);
      check("pc4_data", bus.write_data, 32'h00001004);
      issue(2'b11, 1'b1, 5'd2, 32'hAA, 32'h00002000, 3'd0, 1'b0, 32'h0);
      check("sel11_data", bus.write_data, 32'h000000AA);
      check("sel11_rd", {27'd0, bus.rd_addr}, 32'd2);
      check("sel11_retire", bus.retire_count, 32'd5);

      // Same-cycle loads from word 0x80FF017F
      issue(WB_SEL_LOAD, 1'b1, 5'd10, 32'h1003, 32'h0, F3_LB, 1'b1, 32'h80FF017F);
      check("lb_off3", bus.write_data, 32'hFFFFFF80);
      check("lb_rd", {27'd0, bus.rd_addr}, 32'd10);
      issue(WB_SEL_LOAD, 1'b1, 5'd11, 32'h1003, 32'h0, F3_LBU, 1'b1, 32'h80FF017F);
      check("lbu_off3", bus.write_data, 32'h00000080);
      issue(WB_SEL_LOAD, 1'b1, 5'd12, 32'h1000, 32'h0, F3_LH, 1'b1, 32'h80FF017F);
      check("lh_off0", bus.write_data, 32'h0000017F);
      issue(WB_SEL_LOAD, 1'b1, 5'd13, 32'h1000, 32'h0, F3_LW, 1'b1, 32'h80FF017F);
      check("lw", bus.write_data, 32'h80FF017F);
      issue(WB_SEL_LOAD, 1'b1, 5'd14, 32'h1002, 32'h0, F3_LHU, 1'b1, 32'h80FF017F);
      check("lhu_off2", bus.write_data, 32'h000080FF);
      issue(WB_SEL_LOAD, 1'b1, 5'd15, 32'h1001, 32'h0, F3_LB, 1'b1, 32'h80FF017F);
      check("lb_off1", bus.write_data, 32'h00000001);
      check("sameload_retire", bus.retire_count, 32'd11);
      tick();
      check("we_pulse", {31'd0, bus.RegWrite}, 32'd0);
      check("data_hold_idle", bus.write_data, 32'h00000001);

      // Delayed LH, rvalid three cycles late; stray rvalid in IDLE beforehand
      rvalid_pulse(32'hFFFFFFFF);
      check("stray_rv_we", {31'd0, bus.RegWrite}, 32'd0);
      check("stray_rv_retire", bus.retire_count, 32'd11);
      issue(WB_SEL_LOAD, 1'b1, 5'd7, 32'h2002, 32'h0, F3_LH, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("wait_ready_%0d", i), {31'd0, bus.in_ready}, 32'd0);
         check($sformatf("wait_pend_%0d", i), {31'd0, bus.load_pending}, 32'd1);
         check($sformatf("wait_prd_%0d", i), {27'd0, bus.pending_rd}, 32'd7);
         check($sformatf("wait_we_%0d", i), {31'd0, bus.RegWrite}, 32'd0);
         if (i < 2) begin
            // in_valid while stalled must not be accepted
            issue(WB_SEL_ALU, 1'b1, 5'd20, 32'h999, 32'h0, 3'd0, 1'b0, 32'h0);
         end
      end
      rvalid_pulse(32'h80010000);
      check("dly_we", {31'd0, bus.RegWrite}, 32'd1);
      check("dly_rd", {27'd0, bus.rd_addr}, 32'd7);
      check("dly_data", bus.write_data, 32'hFFFF8001);
      check("dly_retire", bus.retire_count, 32'd12);
      check("dly_ready", {31'd0, bus.in_ready}, 32'd1);
      issue(WB_SEL_ALU, 1'b1, 5'd4, 32'h77, 32'h0, 3'd0, 1'b0, 32'h0);
      check("b2b_data", bus.write_data, 32'h00000077);
      check("b2b_retire", bus.retire_count, 32'd13);

      // Delayed load with reg_write=0: no pending rd reported, no write
      issue(WB_SEL_LOAD, 1'b0, 5'd9, 32'h3000, 32'h0, F3_LW, 1'b0, 32'h0);
      check("nowr_prd", {27'd0, bus.pending_rd}, 32'd0);
      check("nowr_pend", {31'd0, bus.load_pending}, 32'd1);
      rvalid_pulse(32'h12121212);
      check("nowr_ld_we", {31'd0, bus.RegWrite}, 32'd0);
      check("nowr_ld_retire", bus.retire_count, 32'd14);

      // Reset during WAIT_LOAD drops the load
      issue(WB_SEL_LOAD, 1'b1, 5'd9, 32'h3000, 32'h0, F3_LW, 1'b0, 32'h0);
      check("prst_pend", {31'd0, bus.load_pending}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("arst_ready", {31'd0, bus.in_ready}, 32'd1);
      check("arst_retire", bus.retire_count, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      rvalid_pulse(32'h5A5A5A5A);
      check("late_rv_we", {31'd0, bus.RegWrite}, 32'd0);
      check("late_rv_retire", bus.retire_count, 32'd0);
      check("late_rv_pend", {31'd0, bus.load_pending}, 32'd0);
      check("late_rv_rd", {27'd0, bus.rd_addr}, 32'd0);

`ifdef WB_LOAD_TIMEOUT_EN
      begin
         int pend_cycles;
         pend_cycles = 0;
         issue(WB_SEL_LOAD, 1'b1, 5'd6, 32'h4000, 32'h0, F3_LW, 1'b0, 32'h0);
         while (bus.load_pending && pend_cycles < 20) begin
            pend_cycles++;
            tick();
         end
         check("to_wait_cycles", pend_cycles, 32'd4);
         check("to_we", {31'd0, bus.RegWrite}, 32'd1);
         check("to_rd", {27'd0, bus.rd_addr}, 32'd6);
         check("to_data", bus.write_data, 32'd0);
         check("to_err", {31'd0, bus.load_err}, 32'd1);
         check("to_retire", bus.retire_count, 32'd1);
         issue(WB_SEL_ALU, 1'b1, 5'd8, 32'h31, 32'h0, 3'd0, 1'b0, 32'h0);
         issue(WB_SEL_LOAD, 1'b1, 5'd8, 32'h4000, 32'h0, F3_LW, 1'b1, 32'h0BADF00D);
         check("to_err_sticky", {31'd0, bus.load_err}, 32'd1);
         check("to_after_data", bus.write_data, 32'h0BADF00D);
         reset_n = 1'b0;
         tick();
         check("to_err_clr", {31'd0, bus.load_err}, 32'd0);
         reset_n = 1'b1;
         tick();
      end
`else
      issue(WB_SEL_LOAD, 1'b1, 5'd6, 32'h4000, 32'h0, F3_LW, 1'b0, 32'h0);
      for (int i = 0; i < 300; i++) tick();
      check("notimeout_pend", {31'd0, bus.load_pending}, 32'd1);
      check("notimeout_err", {31'd0, bus.load_err}, 32'd0);
      rvalid_pulse(32'h00C0FFEE);
      check("notimeout_data", bus.write_data, 32'h00C0FFEE);
      check("notimeout_retire", bus.retire_count, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
